spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_flash_reader: issues READ (cmd + 24-bit addr) and streams bytes out.
// Revision 1.0
// ----------------------------------------------------------------------------
module spi_flash_reader #(
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [7:0]  DUMMY_BYTE = 8'h00,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  input  logic [15:0] i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic        o_flash_cs_n,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_data,
  input  logic [7:0]  i_spi_data,
  input  logic        i_spi_done
);

  localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (CS_GAP > 0) ? GAP_W'(CS_GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_CMD      = 3'd2,
    S_ADDR     = 3'd3,
    S_READ     = 3'd4,
    S_OUT      = 3'd5,
    S_CS_HOLD  = 3'd6,
    S_FINISH   = 3'd7
  } state_t;

  state_t           state_q;
  logic [23:0]      addr_q;
  logic [15:0]      remain_q;
  logic [1:0]       byte_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             cs_n_q;
  logic             spi_start_q;
  logic [7:0]       spi_data_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic             done_q;

  logic [15:0]      remain_d;
  logic             last_byte_d;

  // Saturating decrement keeps the counter from ever wrapping below zero.
  assign remain_d    = (remain_q != 16'd0) ? (remain_q - 16'd1) : 16'd0;
  assign last_byte_d = (remain_q <= 16'd1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 24'd0;
      remain_q    <= 16'd0;
      byte_cnt_q  <= 2'd0;
      gap_q       <= '0;
      cs_n_q      <= 1'b1;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'd0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      done_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_req) begin
            if (i_len == 16'd0) begin
              state_q <= S_FINISH;
            end else begin
              addr_q   <= i_addr;
              remain_q <= i_len;
              cs_n_q   <= 1'b0;
              gap_q    <= '0;
              if (CS_GAP == 0) begin
                state_q     <= S_CMD;
                spi_start_q <= 1'b1;
                spi_data_q  <= CMD_READ;
              end else begin
                state_q <= S_CS_SETUP;
              end
            end
          end
        end

        S_CS_SETUP: begin
          if (gap_q == GAP_LAST) begin
            state_q     <= S_CMD;
            spi_start_q <= 1'b1;
            spi_data_q  <= CMD_READ;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_CMD: begin
          if (i_spi_done) begin
            state_q     <= S_ADDR;
            byte_cnt_q  <= 2'd0;
            spi_start_q <= 1'b1;
            spi_data_q  <= addr_q[23:16];
          end
        end

        S_ADDR: begin
          if (i_spi_done) begin
            spi_start_q <= 1'b1;
            case (byte_cnt_q)
              2'd0: begin
                byte_cnt_q <= 2'd1;
                spi_data_q <= addr_q[15:8];
              end
              2'd1: begin
                byte_cnt_q <= 2'd2;
                spi_data_q <= addr_q[7:0];
              end
              default: begin
                byte_cnt_q <= 2'd0;
                spi_data_q <= DUMMY_BYTE;
                state_q    <= S_READ;
              end
            endcase
          end
        end

        S_READ: begin
          if (i_spi_done) begin
            rd_data_q  <= i_spi_data;
            rd_valid_q <= 1'b1;
            state_q    <= S_OUT;
          end
        end

        // The next dummy byte is only launched once the consumer takes this one.
        S_OUT: begin
          if (i_rd_ready) begin
            rd_valid_q <= 1'b0;
            remain_q   <= remain_d;
            gap_q      <= '0;
            if (!last_byte_d) begin
              state_q     <= S_READ;
              spi_start_q <= 1'b1;
              spi_data_q  <= DUMMY_BYTE;
            end else if (CS_GAP == 0) begin
              cs_n_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              state_q <= S_CS_HOLD;
            end
          end
        end

        S_CS_HOLD: begin
          if (gap_q == GAP_LAST) begin
            cs_n_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_FINISH: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_flash_cs_n = cs_n_q;
  assign o_spi_start  = spi_start_q;
  assign o_spi_data   = spi_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_flash_reader: directed bench with a byte-level SPI slave model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_spi_flash_reader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic [23:0] i_addr;
  logic [15:0] i_len;
  logic        i_rd_ready;
  logic [7:0]  i_spi_data;
  logic        i_spi_done;
  logic        o_busy, o_done, o_rd_valid, o_flash_cs_n, o_spi_start;
  logic [7:0]  o_rd_data, o_spi_data;

  logic        slv_done;
  logic        spur_done;
  assign i_spi_done = slv_done | spur_done;

  spi_flash_reader dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .i_rd_ready   (i_rd_ready),
    .o_flash_cs_n (o_flash_cs_n),
    .o_spi_start  (o_spi_start),
    .o_spi_data   (o_spi_data),
    .i_spi_data   (i_spi_data),
    .i_spi_done   (i_spi_done)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];
  logic [7:0] resp[$];
  int done_n, cs_low_n, cs_err, bp_err, stab_err, ovl_err;
  int slv_cnt, cur_idx;

  // Slave: answers each start with done three cycles later; read data from resp.
  initial begin
    slv_done   = 1'b0;
    slv_cnt    = 0;
    cur_idx    = 0;
    i_spi_data = 8'h00;
    forever begin
      @(posedge i_clk);
      #1;
      slv_done = 1'b0;
      if (i_reset) begin
        slv_cnt = 0;
      end else begin
        if (slv_cnt != 0) begin
          slv_cnt = slv_cnt - 1;
          if (slv_cnt == 0) begin
            slv_done = 1'b1;
            if (o_spi_data !== tx_log[cur_idx]) stab_err++;
            i_spi_data = (cur_idx >= 4 && (cur_idx - 4) < resp.size()) ? resp[cur_idx - 4] : 8'hEE;
          end
        end
        if (o_spi_start === 1'b1) begin
          if (slv_cnt != 0) ovl_err++;
          cur_idx = tx_log.size();
          tx_log.push_back(o_spi_data);
          slv_cnt = 3;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_done === 1'b1) done_n++;
      if (o_flash_cs_n === 1'b0) cs_low_n++;
      if (o_rd_valid === 1'b1 && i_rd_ready) rx_log.push_back(o_rd_data);
      if (o_spi_start === 1'b1 && o_rd_valid === 1'b1) bp_err++;
      if (slv_cnt != 0 && o_flash_cs_n !== 1'b0 && !i_reset) cs_err++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    rx_log.delete();
    done_n = 0; cs_low_n = 0; cs_err = 0; bp_err = 0; stab_err = 0; ovl_err = 0;
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] l);
    i_req = 1'b1; i_addr = a; i_len = l;
    tick();
    i_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start = done_n;
    for (int k = 0; k < budget; k++) begin
      if (done_n > start) break;
      tick();
    end
    checks++;
    if (done_n <= start) begin
      failures++;
      $display("FAIL %s_timeout got=no_done exp=done_within_%0d", name, budget);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_req = 1'b0; i_addr = 24'd0; i_len = 16'd0;
    i_rd_ready = 1'b1; spur_done = 1'b0;
    repeat (3) tick();
    checks++; if (o_flash_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", o_flash_cs_n); end
    checks++; if (o_spi_start !== 1'b0) begin failures++; $display("FAIL reset_spi_start got=%b exp=0", o_spi_start); end
    checks++; if (o_spi_data !== 8'h00) begin failures++; $display("FAIL reset_spi_data got=%h exp=00", o_spi_data); end
    checks++; if (o_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid); end
    checks++; if (o_rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", o_rd_data); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_reset = 1'b0;
    repeat (2) tick();
    checks++; if (o_busy !== 1'b0 || o_flash_cs_n !== 1'b1) begin failures++; $display("FAIL reset_idle got=busy%b_cs%b exp=busy0_cs1", o_busy, o_flash_cs_n); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_tx [6] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
    logic [7:0] exp_rx [2] = '{8'hA5, 8'h5A};
    clear_logs();
    resp = '{8'hA5, 8'h5A};
    i_rd_ready = 1'b1;
    issue(24'h012345, 16'd2);
    wait_done(300, "basic");
    repeat (5) tick();
    checks++; if (tx_log.size() != 6) begin failures++; $display("FAIL basic_tx_count got=%0d exp=6", tx_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL basic_tx%0d got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (rx_log.size() != 2) begin failures++; $display("FAIL basic_rx_count got=%0d exp=2", rx_log.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rx_log.size() || rx_log[i] !== exp_rx[i]) begin
        failures++; $display("FAIL basic_rx%0d got=%h exp=%h", i, (i < rx_log.size()) ? rx_log[i] : 8'hxx, exp_rx[i]);
      end
    end
    checks++; if (done_n != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_n); end
    checks++; if (cs_err + bp_err + stab_err + ovl_err != 0) begin failures++; $display("FAIL basic_protocol got=cs%0d_bp%0d_stab%0d_ovl%0d exp=all0", cs_err, bp_err, stab_err, ovl_err); end
    checks++; if (o_busy !== 1'b0 || o_flash_cs_n !== 1'b1) begin failures++; $display("FAIL basic_end_idle got=busy%b_cs%b exp=busy0_cs1", o_busy, o_flash_cs_n); end
  endtask

  task automatic test_len0();
    clear_logs();
    i_req = 1'b1; i_addr = 24'h111111; i_len = 16'd0;
    tick();
    i_req = 1'b0;
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL len0_t1 got=done%b_busy%b exp=done0_busy1", o_done, o_busy); end
    tick();
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL len0_done_t2 got=%b exp=1", o_done); end
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL len0_t3 got=done%b_busy%b exp=done0_busy0", o_done, o_busy); end
    repeat (5) tick();
    checks++; if (tx_log.size() != 0) begin failures++; $display("FAIL len0_no_start got=%0d exp=0", tx_log.size()); end
    checks++; if (cs_low_n != 0) begin failures++; $display("FAIL len0_cs_idle got=%0d_low_cycles exp=0", cs_low_n); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", done_n); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_tx [7] = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_rx [3] = '{8'h11, 8'h22, 8'h33};
    int t0, stall_bad;
    clear_logs();
    resp = '{8'h11, 8'h22, 8'h33};
    i_rd_ready = 1'b1;
    issue(24'hABCDEF, 16'd3);
    for (int k = 0; k < 300; k++) begin
      if (rx_log.size() == 1 && o_rd_valid === 1'b1) break;
      tick();
    end
    i_rd_ready = 1'b0;
    checks++; if (o_rd_valid !== 1'b1 || rx_log.size() != 1) begin failures++; $display("FAIL bp_reach_byte2 got=valid%b_rx%0d exp=valid1_rx1", o_rd_valid, rx_log.size()); end
    t0 = tx_log.size();
    stall_bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h22 || tx_log.size() != t0) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall got=%0d_bad_cycles exp=0 (data=%h)", stall_bad, o_rd_data); end
    i_rd_ready = 1'b1;
    wait_done(300, "bp");
    checks++; if (tx_log.size() != 7) begin failures++; $display("FAIL bp_tx_count got=%0d exp=7", tx_log.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL bp_tx%0d got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (rx_log.size() != 3) begin failures++; $display("FAIL bp_rx_count got=%0d exp=3", rx_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_log.size() || rx_log[i] !== exp_rx[i]) begin
        failures++; $display("FAIL bp_rx%0d got=%h exp=%h", i, (i < rx_log.size()) ? rx_log[i] : 8'hxx, exp_rx[i]);
      end
    end
    checks++; if (cs_err + bp_err + stab_err + ovl_err != 0) begin failures++; $display("FAIL bp_protocol got=cs%0d_bp%0d_stab%0d_ovl%0d exp=all0", cs_err, bp_err, stab_err, ovl_err); end
  endtask

  task automatic test_ignore_req();
    logic [7:0] exp_tx [5] = '{8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h00};
    clear_logs();
    resp = '{8'h77};
    i_rd_ready = 1'b1;
    issue(24'h0A0B0C, 16'd1);
    repeat (4) tick();
    i_req = 1'b1; i_addr = 24'hFFFFFF; i_len = 16'd5;
    tick();
    i_req = 1'b0;
    wait_done(300, "ignore");
    repeat (10) tick();
    checks++; if (tx_log.size() != 5) begin failures++; $display("FAIL ignore_tx_count got=%0d exp=5", tx_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL ignore_tx%0d got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (rx_log.size() != 1 || rx_log[0] !== 8'h77) begin failures++; $display("FAIL ignore_rx got=n%0d exp=one_byte_77", rx_log.size()); end
    checks++; if (done_n != 1 || o_busy !== 1'b0) begin failures++; $display("FAIL ignore_done got=done%0d_busy%b exp=done1_busy0", done_n, o_busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_tx [5] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    int d0;
    clear_logs();
    resp.delete();
    i_rd_ready = 1'b1;
    issue(24'h123456, 16'd2);
    for (int k = 0; k < 200; k++) begin
      if (tx_log.size() == 3) break;
      tick();
    end
    checks++; if (tx_log.size() != 3 || o_busy !== 1'b1) begin failures++; $display("FAIL rstmid_reach_addr2 got=tx%0d_busy%b exp=tx3_busy1", tx_log.size(), o_busy); end
    d0 = done_n;
    i_reset = 1'b1;
    #1;
    checks++; if (o_flash_cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=1", o_flash_cs_n); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    checks++; if (o_rd_valid !== 1'b0 || o_spi_start !== 1'b0) begin failures++; $display("FAIL rstmid_outs got=valid%b_start%b exp=0_0", o_rd_valid, o_spi_start); end
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (3) tick();
    checks++; if (done_n != d0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_n, d0); end
    clear_logs();
    resp = '{8'hC3};
    issue(24'h000010, 16'd1);
    wait_done(300, "rstmid");
    checks++; if (tx_log.size() != 5) begin failures++; $display("FAIL rstmid_tx_count got=%0d exp=5", tx_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL rstmid_tx%0d got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (rx_log.size() != 1 || rx_log[0] !== 8'hC3) begin failures++; $display("FAIL rstmid_rx got=n%0d exp=one_byte_C3", rx_log.size()); end
  endtask

  task automatic test_spurious();
    logic [7:0] exp_tx [5] = '{8'h03, 8'h76, 8'h54, 8'h32, 8'h00};
    clear_logs();
    resp = '{8'h9C};
    i_rd_ready = 1'b1;
    i_req = 1'b1; i_addr = 24'h765432; i_len = 16'd1;
    tick();
    i_req = 1'b0;
    spur_done = 1'b1;
    checks++; if (o_flash_cs_n !== 1'b0 || o_spi_start !== 1'b0) begin failures++; $display("FAIL spur_setup1 got=cs%b_start%b exp=cs0_start0", o_flash_cs_n, o_spi_start); end
    tick();
    spur_done = 1'b0;
    checks++; if (o_spi_start !== 1'b0) begin failures++; $display("FAIL spur_setup2 got=start%b exp=0", o_spi_start); end
    tick();
    checks++; if (o_spi_start !== 1'b1 || o_spi_data !== 8'h03) begin failures++; $display("FAIL spur_cmd_start got=start%b_data%h exp=start1_data03", o_spi_start, o_spi_data); end
    wait_done(300, "spur");
    checks++; if (tx_log.size() != 5) begin failures++; $display("FAIL spur_tx_count got=%0d exp=5", tx_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        failures++; $display("FAIL spur_tx%0d got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
      end
    end
    checks++; if (rx_log.size() != 1 || rx_log[0] !== 8'h9C) begin failures++; $display("FAIL spur_rx got=n%0d exp=one_byte_9C", rx_log.size()); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL spur_done_count got=%0d exp=1", done_n); end
  endtask

  initial begin
    spur_done = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_ignore_req();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
